// File: rtl/seven_seg_rx.sv
// Receive side of the two-digit multiplexed seven-segment bus: synchronize, glitch-filter,
// inverse-decode each active-low glyph and rebuild the displayed byte while both digits are fresh.
module seven_seg_rx #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] seg_in,
    output logic [7:0] dout,
    output logic       valid,
    output logic       update,
    output logic       seg_err
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, PARTIAL, LOCKED} state_t;

    logic [7:0]    r_s1, r_s2, r_last;
    logic [CW-1:0] r_cnt;
    logic          r_accept;
    logic [3:0]    r_nib_msb, r_nib_lsb;
    logic          r_got_msb, r_got_lsb;
    logic [AW-1:0] r_age_msb, r_age_lsb;
    state_t        r_state;
    logic [7:0]    r_dout;
    logic          r_valid, r_update, r_seg_err;

    logic [CW-1:0] w_cnt_next;
    logic          w_match;
    logic [3:0]    w_glyph_nib;
    logic          w_refresh_msb, w_refresh_lsb;
    logic [AW-1:0] w_age_msb_next, w_age_lsb_next;
    logic          w_got_msb_next, w_got_lsb_next;
    logic [3:0]    w_nib_msb_next, w_nib_lsb_next;
    logic [7:0]    w_dout_next;
    state_t        w_state_next;

    assign w_cnt_next = (r_s2 != r_last) ? '0 :
                        (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Accept fires only on the transition into CNT_MAX, so a held value is taken once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1     <= 8'hFF;
            r_s2     <= 8'hFF;
            r_last   <= 8'hFF;
            r_cnt    <= '0;
            r_accept <= 1'b0;
        end else begin
            r_s1     <= seg_in;
            r_s2     <= r_s1;
            r_last   <= r_s2;
            r_cnt    <= w_cnt_next;
            r_accept <= (w_cnt_next == CNT_MAX) && (r_cnt != CNT_MAX);
        end
    end

    // r_last holds the value that was stable during the filter run just completed.
    always_comb begin
        w_match     = 1'b1;
        w_glyph_nib = 4'h0;
        case (~r_last[6:0])
            7'h3F: w_glyph_nib = 4'h0;
            7'h06: w_glyph_nib = 4'h1;
            7'h5B: w_glyph_nib = 4'h2;
            7'h4F: w_glyph_nib = 4'h3;
            7'h66: w_glyph_nib = 4'h4;
            7'h6D: w_glyph_nib = 4'h5;
            7'h7D: w_glyph_nib = 4'h6;
            7'h07: w_glyph_nib = 4'h7;
            7'h7F: w_glyph_nib = 4'h8;
            7'h6F: w_glyph_nib = 4'h9;
            7'h77: w_glyph_nib = 4'hA;
            7'h7C: w_glyph_nib = 4'hB;
            7'h39: w_glyph_nib = 4'hC;
            7'h5E: w_glyph_nib = 4'hD;
            7'h79: w_glyph_nib = 4'hE;
            7'h71: w_glyph_nib = 4'hF;
            default: w_match = 1'b0;
        endcase
    end

    always_comb begin
        w_refresh_msb  = r_accept && w_match && !r_last[7];
        w_refresh_lsb  = r_accept && w_match && r_last[7];
        w_age_msb_next = (r_age_msb == AGE_MAX) ? r_age_msb : r_age_msb + 1'b1;
        w_age_lsb_next = (r_age_lsb == AGE_MAX) ? r_age_lsb : r_age_lsb + 1'b1;
        w_got_msb_next = (w_age_msb_next == AGE_MAX) ? 1'b0 : r_got_msb;
        w_got_lsb_next = (w_age_lsb_next == AGE_MAX) ? 1'b0 : r_got_lsb;
        w_nib_msb_next = r_nib_msb;
        w_nib_lsb_next = r_nib_lsb;
        // A refresh landing on the timeout cycle overrides the timeout.
        if (w_refresh_msb) begin
            w_age_msb_next = '0;
            w_got_msb_next = 1'b1;
            w_nib_msb_next = w_glyph_nib;
        end
        if (w_refresh_lsb) begin
            w_age_lsb_next = '0;
            w_got_lsb_next = 1'b1;
            w_nib_lsb_next = w_glyph_nib;
        end
        w_dout_next = {w_nib_msb_next, w_nib_lsb_next};
        case ({w_got_msb_next, w_got_lsb_next})
            2'b11:   w_state_next = LOCKED;
            2'b00:   w_state_next = IDLE;
            default: w_state_next = PARTIAL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_nib_msb <= 4'h0;
            r_nib_lsb <= 4'h0;
            r_got_msb <= 1'b0;
            r_got_lsb <= 1'b0;
            r_age_msb <= '0;
            r_age_lsb <= '0;
            r_dout    <= 8'h00;
            r_valid   <= 1'b0;
            r_update  <= 1'b0;
            r_seg_err <= 1'b0;
        end else begin
            r_nib_msb <= w_nib_msb_next;
            r_nib_lsb <= w_nib_lsb_next;
            r_got_msb <= w_got_msb_next;
            r_got_lsb <= w_got_lsb_next;
            r_age_msb <= w_age_msb_next;
            r_age_lsb <= w_age_lsb_next;
            r_valid   <= (w_state_next == LOCKED);
            r_seg_err <= r_accept && !w_match;
            if (w_state_next == LOCKED) begin
                r_dout   <= w_dout_next;
                r_update <= (r_state != LOCKED) || (w_dout_next != r_dout);
            end else begin
                r_update <= 1'b0;
            end
        end
    end

    assign dout    = r_dout;
    assign valid   = r_valid;
    assign update  = r_update;
    assign seg_err = r_seg_err;
endmodule

// File: tb/tb_seven_seg_rx.sv
// Bench for seven_seg_rx: a timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing and values.
module tb_seven_seg_rx;
    localparam int S = 16;
    localparam int T = 4096;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] seg_in = 8'hFF;
    logic [7:0] dout;
    logic       valid, update, seg_err;

    seven_seg_rx #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST_N(RST_N), .seg_in(seg_in),
        .dout(dout), .valid(valid), .update(update), .seg_err(seg_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic d, input int n);
        return {d, ~GLYPH[n]};
    endfunction

    // Model: a bus value is taken once its synchronized copy has been steady for S
    // samples, takes effect two edges later; a digit is fresh for T edges after it is taken.
    logic [7:0] m_s1 = 8'hFF, m_s2 = 8'hFF, nxt_s2;
    int         m_run = 2;
    bit         ev_a = 0, ev_b = 0;
    logic [7:0] ev_a_val = 0, ev_b_val = 0;
    bit         have_m = 0, have_l = 0;
    int         ref_m = 0, ref_l = 0;
    logic [3:0] nib_m = 0, nib_l = 0;
    logic [7:0] e_dout = 0, nd;
    logic       e_valid = 0, e_upd = 0, e_err = 0;
    bit         found, fresh_m, fresh_l;
    int         now;
    logic [6:0] p;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_s1 = 8'hFF; m_s2 = 8'hFF; m_run = 2;
            ev_a = 0; ev_b = 0; have_m = 0; have_l = 0;
            nib_m = 0; nib_l = 0;
            e_dout = 0; e_valid = 0; e_upd = 0; e_err = 0;
        end else begin
            now = cyc + 1;
            e_err = 0;
            e_upd = 0;
            if (ev_b) begin
                p = ~ev_b_val[6:0];
                found = 0;
                for (int i = 0; i < 16; i++) begin
                    if (!found && GLYPH[i] == p) begin
                        found = 1;
                        if (ev_b_val[7]) begin nib_l = 4'(i); ref_l = now; have_l = 1; end
                        else             begin nib_m = 4'(i); ref_m = now; have_m = 1; end
                    end
                end
                if (!found) e_err = 1;
            end
            ev_b = ev_a;
            ev_b_val = ev_a_val;
            nxt_s2 = m_s1;
            m_s1 = seg_in;
            if (nxt_s2 == m_s2) m_run++;
            else m_run = 1;
            m_s2 = nxt_s2;
            ev_a = (m_run == S);
            ev_a_val = m_s2;
            fresh_m = have_m && (now - ref_m < T);
            fresh_l = have_l && (now - ref_l < T);
            if (fresh_m && fresh_l) begin
                nd = {nib_m, nib_l};
                e_upd = !e_valid || (nd != e_dout);
                e_dout = nd;
            end
            e_valid = fresh_m && fresh_l;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cyc_dout", {24'h0, dout}, {24'h0, e_dout});
            chk("cyc_valid", {31'h0, valid}, {31'h0, e_valid});
            chk("cyc_update", {31'h0, update}, {31'h0, e_upd});
            chk("cyc_seg_err", {31'h0, seg_err}, {31'h0, e_err});
        end
    end

    int upd_cnt = 0, err_cnt = 0, rise_cyc = -1;
    logic [7:0] rise_dout = 0;
    logic valid_q = 0;
    always @(negedge CLK) begin
        if (update) upd_cnt++;
        if (seg_err) err_cnt++;
        if (valid && !valid_q) begin
            rise_cyc = cyc;
            rise_dout = dout;
        end
        valid_q = valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    int t0, tl, t2, t3, t4, lref, u0, e0;

    initial begin
        seg_in = pat(1'b0, 3);
        step(3);
        chk_en = 1'b1;
        chk("rst_dout", {24'h0, dout}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_update", {31'h0, update}, 32'h0);
        chk("rst_seg_err", {31'h0, seg_err}, 32'h0);
        RST_N = 1'b1;

        // loopback-style transmitter showing 8'h3A: msb digit, then lsb digit, 1024 cycles each
        t0 = cyc; u0 = upd_cnt; e0 = err_cnt;
        step(1024);
        tl = cyc;
        seg_in = pat(1'b1, 10);
        step(1024);
        seg_in = pat(1'b0, 3);
        step(200);
        chk("loop_rise_time", rise_cyc, tl + 19);
        chk("loop_rise_bound", {31'h0, (rise_cyc - t0) <= 2200}, 32'h1);
        chk("loop_dout", {24'h0, rise_dout}, 32'h3A);
        chk("loop_updates", upd_cnt - u0, 1);
        chk("loop_seg_err", err_cnt - e0, 0);

        // asynchronous reset while locked
        chk("pre_rst_valid", {31'h0, valid}, 32'h1);
        RST_N = 1'b0;
        #1;
        chk("async_rst_dout", {24'h0, dout}, 32'h0);
        chk("async_rst_valid", {31'h0, valid}, 32'h0);
        step(2);
        RST_N = 1'b1;

        // direct drive: lsb '1' then msb 'F' -> F1
        u0 = upd_cnt;
        seg_in = pat(1'b1, 1);
        step(20);
        chk("one_digit_valid", {31'h0, valid}, 32'h0);
        t2 = cyc;
        seg_in = pat(1'b0, 15);
        wait_until(t2 + 18);
        chk("direct_valid_early", {31'h0, valid}, 32'h0);
        step(1);
        chk("direct_valid", {31'h0, valid}, 32'h1);
        chk("direct_dout", {24'h0, dout}, 32'hF1);
        chk("model_dout", {24'h0, e_dout}, 32'hF1);
        step(5);
        chk("direct_updates", upd_cnt - u0, 1);

        // glitch on lsb pattern shorter than the filter window
        u0 = upd_cnt;
        seg_in = pat(1'b1, 3);
        step(10);
        seg_in = pat(1'b0, 15);
        step(40);
        chk("glitch_dout", {24'h0, dout}, 32'hF1);
        chk("glitch_updates", upd_cnt - u0, 0);

        // blank glyph
        e0 = err_cnt;
        t3 = cyc;
        seg_in = 8'hFF;
        wait_until(t3 + 18);
        chk("blank_err_early", {31'h0, seg_err}, 32'h0);
        step(1);
        chk("blank_err", {31'h0, seg_err}, 32'h1);
        chk("model_err", {31'h0, e_err}, 32'h1);
        chk("blank_dout", {24'h0, dout}, 32'hF1);
        chk("blank_valid", {31'h0, valid}, 32'h1);
        wait_until(t3 + 20);
        chk("blank_err_count", err_cnt - e0, 1);

        // refresh lsb, then hold msb '0' forever: lsb times out first
        t4 = cyc;
        seg_in = pat(1'b1, 1);
        wait_until(t4 + 20);
        seg_in = pat(1'b0, 0);
        lref = t4 + 19;
        wait_until(t4 + 40);
        chk("hold_dout", {24'h0, dout}, 32'h01);
        wait_until(lref + T - 1);
        chk("timeout_valid_before", {31'h0, valid}, 32'h1);
        step(1);
        chk("timeout_valid_after", {31'h0, valid}, 32'h0);
        chk("timeout_dout_hold", {24'h0, dout}, 32'h01);
        wait_until(lref + 20 + T + 3);
        chk("both_stale_valid", {31'h0, valid}, 32'h0);
        chk("both_stale_dout", {24'h0, dout}, 32'h01);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
